// File: rtl/rom_pkg.sv
// Shared types and helpers for the burst-read ROM: engine state encoding and
// the default word generator used when no init file is supplied.
package rom_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Default ROM contents: (i*8'h11 ^ 8'h5A), truncated or zero-extended to data_w.
  function automatic logic [63:0] default_word(input int unsigned idx,
                                               input int unsigned data_w);
    logic [7:0]  base;
    logic [63:0] mask;
    base = 8'(idx * 32'h11) ^ 8'h5A;
    mask = (data_w >= 64) ? '1 : ((64'd1 << data_w) - 64'd1);
    return {56'd0, base} & mask;
  endfunction

endpackage

// File: rtl/rom_array.sv
// DEPTH x DATA_W read-only storage with a registered, enable-gated read port.
// Contents are generated by default_word() for every location.
module rom_array
  import rom_pkg::*;
#(
  parameter int    DATA_W    = 8,
  parameter int    DEPTH     = 16,
  parameter int    ADDR_W    = 4,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
      assign mem[i] = DATA_W'(default_word(i, DATA_W));
    end
  endgenerate

  // NOTE: the read register and the array carry no reset; contents are fixed
  // at initialisation and resetting an array would force it into flops.
  always_ff @(posedge clk) begin
    if (en) begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/rom_burst_reader.sv
// Synchronous ROM behind a burst-read engine: one request (addr, len) streams
// len+1 words over a valid/ready channel, wrapping the address modulo DEPTH.
module rom_burst_reader
  import rom_pkg::*;
#(
  parameter int    DATA_W    = 8,
  parameter int    DEPTH     = 16,
  parameter int    LEN_W     = 4,
  parameter string INIT_FILE = "",
  localparam int   ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rd_err,
  output logic              busy
);

  localparam logic [31:0]       DEPTH_U  = 32'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cur_addr, next_addr, rom_addr;
  logic [LEN_W-1:0]    cnt;
  logic                rd_last_q, rd_err_q;
  logic                accept, xfer, more, done;
  logic                req_in_range, rom_en;
  logic [DATA_W-1:0]   rom_dout;

  // Request inputs are only looked at in the acceptance cycle, so X on them
  // while req_valid is low never reaches any register.
  assign accept       = (state == IDLE) && req_valid;
  assign xfer         = (state == BURST) && rd_ready;
  assign more         = xfer && (cnt != '0);
  assign done         = xfer && (cnt == '0);
  assign req_in_range = 32'(req_addr) < DEPTH_U;

  // NOTE: combinational blocks assign every output a default first, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = BURST;
      BURST:   if (done)      state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // An out-of-range burst parks on its start address; otherwise step and wrap.
  always_comb begin
    next_addr = cur_addr;
    if (!rd_err_q) begin
      next_addr = (cur_addr == LAST_ADR) ? '0 : cur_addr + ADDR_W'(1);
    end
  end

  // The array is never indexed out of range; error beats are masked anyway.
  always_comb begin
    rom_en   = accept || more;
    rom_addr = '0;
    if (accept) begin
      rom_addr = req_in_range ? req_addr : '0;
    end else if (!rd_err_q) begin
      rom_addr = next_addr;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      cnt       <= '0;
      rd_last_q <= 1'b0;
      rd_err_q  <= 1'b0;
    end else if (accept) begin
      cur_addr  <= req_addr;
      cnt       <= req_len;
      rd_last_q <= (req_len == '0);
      rd_err_q  <= !req_in_range;
    end else if (more) begin
      cur_addr  <= next_addr;
      cnt       <= cnt - LEN_W'(1);
      rd_last_q <= (cnt == LEN_W'(1));
    end else if (done) begin
      rd_last_q <= 1'b0;
      rd_err_q  <= 1'b0;
    end
  end

  rom_array #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clk  (clk),
    .en   (rom_en),
    .addr (rom_addr),
    .dout (rom_dout)
  );

  // rd_valid is the state register itself, so reset drops it asynchronously
  // and the data mask zeroes rd_data in the same instant.
  assign rd_valid  = (state == BURST);
  assign busy      = (state == BURST);
  assign req_ready = (state == IDLE);
  assign rd_last   = rd_last_q;
  assign rd_err    = rd_err_q;
  assign rd_data   = (rd_valid && !rd_err_q) ? rom_dout : '0;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader: a table of free-flowing bursts plus
// hand-written reset, handshake, backpressure and non-power-of-two sequences.
module tb_rom_burst_reader;

  logic clk = 1'b0;
  logic rst_n;

  logic       req_valid, req_ready, rd_valid, rd_ready, rd_last, rd_err, busy;
  logic [3:0] req_addr, req_len;
  logic [7:0] rd_data;

  logic       b_req_valid, b_req_ready, b_rd_valid, b_rd_ready, b_rd_last, b_rd_err, b_busy;
  logic [3:0] b_req_addr, b_req_len;
  logic [7:0] b_rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0]  addr;
    logic [3:0]  len;
    logic [31:0] exp;   // up to four beats, first beat in the top byte
  } vec_t;

  vec_t vecs [5];

  logic       bp_ready [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] bp_data  [5] = '{8'h5A, 8'h4B, 8'h4B, 8'h4B, 8'h78};
  logic       bp_last  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] rst_data [4] = '{8'h78, 8'h69, 8'h1E, 8'h0F};

  always #5 clk = ~clk;

  rom_burst_reader #(
    .DATA_W(8), .DEPTH(16), .LEN_W(4), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_err(rd_err), .busy(busy)
  );

  rom_burst_reader #(
    .DATA_W(8), .DEPTH(12), .LEN_W(4), .INIT_FILE("")
  ) dut12 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_addr(b_req_addr), .req_len(b_req_len),
    .rd_valid(b_rd_valid), .rd_ready(b_rd_ready),
    .rd_data(b_rd_data), .rd_last(b_rd_last), .rd_err(b_rd_err), .busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called on a negedge with the 16-deep engine idle; returns on the negedge
  // after acceptance, where the first beat must already be presented.
  task automatic start16(input logic [3:0] a, input logic [3:0] l);
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 'x;
    req_len   = 'x;
  endtask

  task automatic start12(input logic [3:0] a, input logic [3:0] l);
    b_req_addr  = a;
    b_req_len   = l;
    b_req_valid = 1'b1;
    @(negedge clk);
    b_req_valid = 1'b0;
    b_req_addr  = 'x;
    b_req_len   = 'x;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{addr: 4'd1,  len: 4'd0, exp: 32'h4B00_0000};
    vecs[1] = '{addr: 4'd14, len: 4'd3, exp: 32'hB4A5_5A4B};
    vecs[2] = '{addr: 4'd0,  len: 4'd2, exp: 32'h5A4B_7800};
    vecs[3] = '{addr: 4'd5,  len: 4'd1, exp: 32'h0F3C_0000};
    vecs[4] = '{addr: 4'd15, len: 4'd1, exp: 32'hA55A_0000};

    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_addr    = 'x;
    req_len     = 'x;
    rd_ready    = 1'b0;
    b_req_valid = 1'b0;
    b_req_addr  = 'x;
    b_req_len   = 'x;
    b_rd_ready  = 1'b1;

    #1;
    check("reset rd_valid",  32'(rd_valid),  32'd0);
    check("reset busy",      32'(busy),      32'd0);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rd_data",   32'(rd_data),   32'd0);
    check("reset rd_last",   32'(rd_last),   32'd0);
    check("reset rd_err",    32'(rd_err),    32'd0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle with X request rd_valid", 32'(rd_valid), 32'd0);
    check("idle with X request rd_data",  32'(rd_data),  32'd0);

    // Table of bursts with the consumer always ready.
    for (int v = 0; v < 5; v++) begin
      start16(vecs[v].addr, vecs[v].len);
      for (int b = 0; b <= int'(vecs[v].len); b++) begin
        check($sformatf("vec%0d beat%0d rd_valid", v, b), 32'(rd_valid), 32'd1);
        check($sformatf("vec%0d beat%0d req_ready", v, b), 32'(req_ready), 32'd0);
        check($sformatf("vec%0d beat%0d rd_data", v, b), 32'(rd_data),
              32'(vecs[v].exp[31-8*b -: 8]));
        check($sformatf("vec%0d beat%0d rd_last", v, b), 32'(rd_last),
              32'(b == int'(vecs[v].len)));
        check($sformatf("vec%0d beat%0d rd_err", v, b), 32'(rd_err), 32'd0);
        @(negedge clk);
      end
      check($sformatf("vec%0d end rd_valid", v), 32'(rd_valid), 32'd0);
      check($sformatf("vec%0d end req_ready", v), 32'(req_ready), 32'd1);
    end

    // Backpressure: consumer ready pattern 1,0,0,1,1 over three beats.
    start16(4'd0, 4'd2);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp cyc%0d rd_valid", k), 32'(rd_valid), 32'd1);
      check($sformatf("bp cyc%0d rd_data", k),  32'(rd_data),  32'(bp_data[k]));
      check($sformatf("bp cyc%0d rd_last", k),  32'(rd_last),  32'(bp_last[k]));
      rd_ready = bp_ready[k];
      @(negedge clk);
    end
    check("bp end rd_valid", 32'(rd_valid), 32'd0);
    rd_ready = 1'b1;

    // Handshake: req_valid held high straight through a two-beat burst.
    req_addr  = 4'd3;
    req_len   = 4'd1;
    req_valid = 1'b1;
    @(negedge clk);
    check("hs beat0 rd_data",   32'(rd_data),   32'h69);
    check("hs beat0 req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("hs beat1 rd_data",   32'(rd_data),   32'h1E);
    check("hs beat1 rd_last",   32'(rd_last),   32'd1);
    check("hs beat1 req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("hs bubble rd_valid",  32'(rd_valid),  32'd0);
    check("hs bubble req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("hs second rd_valid",  32'(rd_valid),  32'd1);
    check("hs second rd_data",   32'(rd_data),   32'h69);
    check("hs second req_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    req_addr  = 'x;
    req_len   = 'x;
    @(negedge clk);
    check("hs second beat1 rd_data", 32'(rd_data), 32'h1E);
    @(negedge clk);
    check("hs second end rd_valid", 32'(rd_valid), 32'd0);

    // Reset in the middle of an eight-beat burst, after three transfers.
    start16(4'd2, 4'd7);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("rst burst beat%0d rd_data", b), 32'(rd_data), 32'(rst_data[b]));
      if (b < 3) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid reset rd_valid",  32'(rd_valid),  32'd0);
    check("mid reset busy",      32'(busy),      32'd0);
    check("mid reset req_ready", 32'(req_ready), 32'd1);
    check("mid reset rd_data",   32'(rd_data),   32'd0);
    check("mid reset rd_last",   32'(rd_last),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start16(4'd0, 4'd0);
    check("post reset rd_data", 32'(rd_data), 32'h5A);
    check("post reset rd_last", 32'(rd_last), 32'd1);
    @(negedge clk);
    check("post reset end rd_valid", 32'(rd_valid), 32'd0);

    // Non-power-of-two depth: out-of-range start, then wrap from the top word.
    start12(4'd13, 4'd1);
    check("d12 oor beat0 rd_valid", 32'(b_rd_valid), 32'd1);
    check("d12 oor beat0 rd_data",  32'(b_rd_data),  32'd0);
    check("d12 oor beat0 rd_err",   32'(b_rd_err),   32'd1);
    check("d12 oor beat0 rd_last",  32'(b_rd_last),  32'd0);
    @(negedge clk);
    check("d12 oor beat1 rd_data",  32'(b_rd_data),  32'd0);
    check("d12 oor beat1 rd_err",   32'(b_rd_err),   32'd1);
    check("d12 oor beat1 rd_last",  32'(b_rd_last),  32'd1);
    @(negedge clk);
    check("d12 oor end rd_valid",   32'(b_rd_valid), 32'd0);
    start12(4'd11, 4'd1);
    check("d12 wrap beat0 rd_data", 32'(b_rd_data),  32'hE1);
    check("d12 wrap beat0 rd_err",  32'(b_rd_err),   32'd0);
    @(negedge clk);
    check("d12 wrap beat1 rd_data", 32'(b_rd_data),  32'h5A);
    check("d12 wrap beat1 rd_last", 32'(b_rd_last),  32'd1);
    @(negedge clk);
    check("d12 wrap end busy",      32'(b_busy),     32'd0);
    check("d12 wrap end req_ready", 32'(b_req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
